// File: rtl/uart_tx_sched_pkg.sv
// Shared types and helpers for the UART transmit scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_tx_sched_pkg;

  // Cycles to wait for the transmitter to report Busy after a DATA_VALID pulse
  localparam int START_TIMEOUT_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_ISSUE      = 2'd1,
    ST_WAIT_START = 2'd2,
    ST_WAIT_DONE  = 2'd3
  } state_e;

  // Width of a requester index; never narrower than one bit
  function automatic int gid_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Rotating-priority picker: first request at or after ptr_i, wrapping.
// Latency: combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module uart_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  int             cand;
  logic [IDX_W-1:0] cand_idx;
  logic           found;

  // Walk the request vector starting at the pointer and keep the first hit
  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = int'(ptr_i) + off;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cand_idx = IDX_W'(cand);
      if (!found && req_i[cand_idx]) begin
        found           = 1'b1;
        gnt_o[cand_idx] = 1'b1;
        idx_o           = cand_idx;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte producers.
// Latency: grant edge -> DATA_VALID/ACK next cycle; Busy fall -> FRAME_DONE next cycle.
// Backpressure: grants only in IDLE with TX_BUSY low; requests held until ACK.
module uart_tx_scheduler
  import uart_tx_sched_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = START_TIMEOUT_DEF,
  localparam int GID_W        = gid_width(NUM_REQ)
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            REQ_VALID,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
  input  logic [NUM_REQ-1:0]            REQ_PAR_EN,
  input  logic [NUM_REQ-1:0]            REQ_PAR_TYP,
  output logic [NUM_REQ-1:0]            REQ_ACK,
  output logic [DATA_WIDTH-1:0]         TX_P_DATA,
  output logic                          TX_DATA_VALID,
  output logic                          TX_PAR_EN,
  output logic                          TX_PAR_TYP,
  input  logic                          TX_BUSY,
  output logic [GID_W-1:0]              GRANT_ID,
  output logic                          FRAME_DONE,
  output logic                          START_ERR
);

  // Counter holds 0..START_TIMEOUT plus headroom so saturation is explicit
  localparam int                 CNT_W   = $clog2(START_TIMEOUT + 2);
  localparam logic [CNT_W-1:0]   CNT_MAX = '1;
  localparam logic [CNT_W:0]     TO_LIM  = (CNT_W + 1)'(START_TIMEOUT);

  state_e                  state_q, state_d;
  logic [GID_W-1:0]        ptr_q, ptr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W:0]          cnt_inc;
  logic [DATA_WIDTH-1:0]   p_data_q, p_data_d;
  logic                    par_en_q, par_en_d;
  logic                    par_typ_q, par_typ_d;
  logic                    dv_q, dv_d;
  logic [NUM_REQ-1:0]      ack_q, ack_d;
  logic [GID_W-1:0]        gid_q, gid_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic [NUM_REQ-1:0]      win_gnt;
  logic [GID_W-1:0]        win_idx;
  logic                    win_any;

  uart_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (GID_W)
  ) u_arb (
    .req_i (REQ_VALID),
    .ptr_i (ptr_q),
    .gnt_o (win_gnt),
    .idx_o (win_idx),
    .any_o (win_any)
  );

  // Frame sequencing: grant, issue pulse, wait for Busy rise, wait for Busy fall
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    p_data_d  = p_data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    gid_d     = gid_q;
    dv_d      = 1'b0;
    ack_d     = '0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    cnt_inc   = {1'b0, cnt_q} + (CNT_W + 1)'(1);
    unique case (state_q)
      ST_IDLE: begin
        // A transmitter still busy from before a reset must drain first
        if (!TX_BUSY && win_any) begin
          p_data_d  = REQ_DATA[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
          par_en_d  = REQ_PAR_EN[win_idx];
          par_typ_d = REQ_PAR_TYP[win_idx];
          gid_d     = win_idx;
          ptr_d     = (win_idx == GID_W'(NUM_REQ - 1)) ? '0 : win_idx + GID_W'(1);
          dv_d      = 1'b1;
          ack_d     = win_gnt;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        if (TX_BUSY) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_inc >= TO_LIM) begin
          // Byte is dropped; the requester already saw its ACK
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_inc[CNT_W-1:0];
        end
      end
      ST_WAIT_DONE: begin
        if (!TX_BUSY) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      p_data_q  <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      dv_q      <= 1'b0;
      ack_q     <= '0;
      gid_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      p_data_q  <= p_data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      dv_q      <= dv_d;
      ack_q     <= ack_d;
      gid_q     <= gid_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign REQ_ACK       = ack_q;
  assign TX_P_DATA     = p_data_q;
  assign TX_DATA_VALID = dv_q;
  assign TX_PAR_EN     = par_en_q;
  assign TX_PAR_TYP    = par_typ_q;
  assign GRANT_ID      = gid_q;
  assign FRAME_DONE    = done_q;
  assign START_ERR     = err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed + randomized bench for uart_tx_scheduler with a transaction-level model.
// The transmitter's Busy is played by the bench with chosen start delay and length.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_uart_tx_scheduler;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int T  = 4;

  logic            CLK = 1'b0;
  logic            RST;
  logic [N-1:0]    REQ_VALID;
  logic [N*DW-1:0] REQ_DATA;
  logic [N-1:0]    REQ_PAR_EN;
  logic [N-1:0]    REQ_PAR_TYP;
  logic [N-1:0]    REQ_ACK;
  logic [DW-1:0]   TX_P_DATA;
  logic            TX_DATA_VALID;
  logic            TX_PAR_EN;
  logic            TX_PAR_TYP;
  logic            TX_BUSY;
  logic [1:0]      GRANT_ID;
  logic            FRAME_DONE;
  logic            START_ERR;

  uart_tx_scheduler #(.DATA_WIDTH(DW), .NUM_REQ(N), .START_TIMEOUT(T)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .REQ_VALID     (REQ_VALID),
    .REQ_DATA      (REQ_DATA),
    .REQ_PAR_EN    (REQ_PAR_EN),
    .REQ_PAR_TYP   (REQ_PAR_TYP),
    .REQ_ACK       (REQ_ACK),
    .TX_P_DATA     (TX_P_DATA),
    .TX_DATA_VALID (TX_DATA_VALID),
    .TX_PAR_EN     (TX_PAR_EN),
    .TX_PAR_TYP    (TX_PAR_TYP),
    .TX_BUSY       (TX_BUSY),
    .GRANT_ID      (GRANT_ID),
    .FRAME_DONE    (FRAME_DONE),
    .START_ERR     (START_ERR)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  // Model state: round-robin pointer and the frame currently on the wire
  int           m_ptr = 0;
  logic [DW-1:0] e_data;
  logic         e_pe;
  logic         e_pt;
  logic [1:0]   e_gid;
  logic [N-1:0] pend_set = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Rotate the request vector so the pointer sits at bit 0, take the lowest set bit
  function automatic int model_pick(input logic [N-1:0] v, input int p);
    logic [2*N-1:0] dbl;
    dbl = {v, v} >> p;
    for (int k = 0; k < N; k++) begin
      if (dbl[k]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic tick();
    @(negedge CLK);
    REQ_VALID = REQ_VALID | pend_set;
    pend_set  = '0;
  endtask

  // Between pulses: nothing fires and the captured frame stays put
  task automatic quiet_chk(input string tag);
    chk({tag, ".dv"},   32'(TX_DATA_VALID), 32'd0);
    chk({tag, ".ack"},  32'(REQ_ACK),       32'd0);
    chk({tag, ".done"}, 32'(FRAME_DONE),    32'd0);
    chk({tag, ".err"},  32'(START_ERR),     32'd0);
    chk({tag, ".data"}, 32'(TX_P_DATA),     32'(e_data));
    chk({tag, ".pe"},   32'(TX_PAR_EN),     32'(e_pe));
    chk({tag, ".pt"},   32'(TX_PAR_TYP),    32'(e_pt));
    chk({tag, ".gid"},  32'(GRANT_ID),      32'(e_gid));
  endtask

  // The next rising edge is expected to be a grant edge
  task automatic grant_step(input string tag, output int w);
    logic [N-1:0] exp_ack;
    w = model_pick(REQ_VALID, m_ptr);
    if (w < 0) w = 0;
    e_data  = REQ_DATA[w*DW +: DW];
    e_pe    = REQ_PAR_EN[w];
    e_pt    = REQ_PAR_TYP[w];
    e_gid   = 2'(w);
    exp_ack = '0;
    exp_ack[w] = 1'b1;
    tick();
    chk({tag, ".dv"},   32'(TX_DATA_VALID), 32'd1);
    chk({tag, ".ack"},  32'(REQ_ACK),       32'(exp_ack));
    chk({tag, ".gid"},  32'(GRANT_ID),      32'(e_gid));
    chk({tag, ".data"}, 32'(TX_P_DATA),     32'(e_data));
    chk({tag, ".pe"},   32'(TX_PAR_EN),     32'(e_pe));
    chk({tag, ".pt"},   32'(TX_PAR_TYP),    32'(e_pt));
    m_ptr = (w + 1) % N;
    REQ_VALID[w] = 1'b0;
  endtask

  // Called at the negedge of the DATA_VALID cycle. d=0: Busy never rises.
  task automatic finish_frame(input string tag, input int d, input int len);
    if (d == 0) begin
      for (int i = 1; i <= T; i++) begin
        tick();
        quiet_chk({tag, ".to_wait"});
      end
      tick();
      chk({tag, ".start_err"}, 32'(START_ERR),  32'd1);
      chk({tag, ".no_done"},   32'(FRAME_DONE), 32'd0);
      chk({tag, ".dv_off"},    32'(TX_DATA_VALID), 32'd0);
    end else begin
      for (int i = 1; i < d; i++) begin
        tick();
        quiet_chk({tag, ".pre_busy"});
      end
      tick();
      TX_BUSY = 1'b1;
      quiet_chk({tag, ".busy_rise"});
      for (int i = 1; i < len; i++) begin
        tick();
        quiet_chk({tag, ".busy"});
      end
      tick();
      TX_BUSY = 1'b0;
      quiet_chk({tag, ".busy_fall"});
      tick();
      chk({tag, ".frame_done"}, 32'(FRAME_DONE),    32'd1);
      chk({tag, ".no_err"},     32'(START_ERR),     32'd0);
      chk({tag, ".dv_off"},     32'(TX_DATA_VALID), 32'd0);
      chk({tag, ".data_hold"},  32'(TX_P_DATA),     32'(e_data));
    end
  endtask

  task automatic outputs_zero(input string tag);
    chk({tag, ".dv"},   32'(TX_DATA_VALID), 32'd0);
    chk({tag, ".ack"},  32'(REQ_ACK),       32'd0);
    chk({tag, ".data"}, 32'(TX_P_DATA),     32'd0);
    chk({tag, ".pe"},   32'(TX_PAR_EN),     32'd0);
    chk({tag, ".pt"},   32'(TX_PAR_TYP),    32'd0);
    chk({tag, ".gid"},  32'(GRANT_ID),      32'd0);
    chk({tag, ".done"}, 32'(FRAME_DONE),    32'd0);
    chk({tag, ".err"},  32'(START_ERR),     32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int d;
    int len;
    RST         = 1'b0;
    REQ_VALID   = '0;
    REQ_DATA    = '0;
    REQ_PAR_EN  = '0;
    REQ_PAR_TYP = '0;
    TX_BUSY     = 1'b0;

    // Reset state
    repeat (3) @(negedge CLK);
    outputs_zero("reset");
    RST = 1'b1;
    m_ptr = 0;

    // Contention: all four requesting, per-requester parity config
    REQ_PAR_EN  = 4'b1110;
    REQ_PAR_TYP = 4'b1010;
    for (int i = 0; i < N; i++) REQ_DATA[i*DW +: DW] = DW'(8'h10 + i);
    REQ_VALID = '1;
    for (int f = 0; f < 5; f++) begin
      grant_step("cont", w);
      chk("cont.order", 32'(w), 32'(f % N));
      if (f < 4) pend_set[w] = 1'b1;
      else REQ_VALID = '0;
      finish_frame("cont", 2, 3 + f);
    end
    repeat (3) begin
      tick();
      chk("idle.no_dv", 32'(TX_DATA_VALID), 32'd0);
    end

    // Single request from requester 2
    REQ_DATA[2*DW +: DW] = 8'hA5;
    REQ_PAR_EN[2]  = 1'b1;
    REQ_PAR_TYP[2] = 1'b0;
    REQ_VALID[2]   = 1'b1;
    grant_step("single", w);
    chk("single.ack_bits", 32'(REQ_ACK), 32'h4);
    chk("single.data_a5",  32'(TX_P_DATA), 32'hA5);
    finish_frame("single", 3, 4);

    // Start timeout, then the next requester is served
    REQ_VALID = 4'b1010;
    grant_step("to", w);
    chk("to.winner", 32'(w), 32'd3);
    finish_frame("to", 0, 0);
    grant_step("after_to", w);
    chk("after_to.winner", 32'(w), 32'd1);
    finish_frame("after_to", T, 2);

    // Randomized traffic with late drops and occasional timeouts
    REQ_VALID = 4'b0001;
    for (int f = 0; f < 40; f++) begin
      grant_step("rnd", w);
      for (int i = 0; i < N; i++) begin
        REQ_DATA[i*DW +: DW] = DW'($urandom);
        REQ_PAR_EN[i]  = 1'($urandom);
        REQ_PAR_TYP[i] = 1'($urandom);
        if (i != w) begin
          if (!REQ_VALID[i] && $urandom_range(2, 0) == 0) REQ_VALID[i] = 1'b1;
          else if (REQ_VALID[i] && $urandom_range(7, 0) == 0) REQ_VALID[i] = 1'b0;
        end
      end
      if (REQ_VALID == '0) REQ_VALID[(w + 1 + $urandom_range(N - 2, 0)) % N] = 1'b1;
      d   = ($urandom_range(5, 0) == 0) ? 0 : $urandom_range(T, 1);
      len = $urandom_range(5, 1);
      finish_frame("rnd", d, len);
    end

    // Late drop: requester 1 withdraws mid-frame and must never be acknowledged
    REQ_VALID = 4'b0001;
    m_ptr = m_ptr;
    grant_step("late", w);
    REQ_VALID[1] = 1'b1;
    tick();
    REQ_VALID[1] = 1'b0;
    TX_BUSY = 1'b1;
    chk("late.no_ack", 32'(REQ_ACK), 32'd0);
    tick();
    TX_BUSY = 1'b0;
    tick();
    chk("late.done", 32'(FRAME_DONE), 32'd1);
    repeat (4) begin
      tick();
      chk("late.no_dv",  32'(TX_DATA_VALID), 32'd0);
      chk("late.no_ack", 32'(REQ_ACK),       32'd0);
    end

    // Reset during WAIT_DONE with Busy still high
    REQ_VALID[2] = 1'b1;
    grant_step("mid", w);
    tick();
    TX_BUSY = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    #1;
    outputs_zero("mid_rst");
    m_ptr = 0;
    @(negedge CLK);
    RST = 1'b1;
    REQ_VALID = 4'b1001;
    repeat (3) begin
      tick();
      chk("mid.hold_dv", 32'(TX_DATA_VALID), 32'd0);
    end
    TX_BUSY = 1'b0;
    grant_step("post_rst", w);
    chk("post_rst.winner", 32'(w), 32'd0);
    finish_frame("post_rst", 1, 2);
    grant_step("post_rst2", w);
    chk("post_rst2.winner", 32'(w), 32'd3);
    finish_frame("post_rst2", 2, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin scheduler that shares one UART_TX_TOP transmitter among NUM_REQ byte producers. It arbitrates between pending requests and captures the winner's byte and per-requester parity configuration. It then pulses DATA_VALID into the transmitter and tracks the frame through Busy until completion. It sits directly upstream of UART_TX_TOP and drives its P_DATA, DATA_VALID, PAR_EN and PAR_TYP.

## Interface
- DATA_WIDTH, 8, frame payload width; matches the transmitter.
- NUM_REQ, 4, number of requesters; 2..16.
- START_TIMEOUT, 4, maximum number of cycles to wait for TX_BUSY to rise after issue.

Ports:
- CLK  in  1  single clock, shared with UART_TX_TOP.
- RST  in  1  asynchronous, active-low reset.
- REQ_VALID  in  NUM_REQ  per-requester request; held until the matching REQ_ACK.
- REQ_DATA  in  NUM_REQ*DATA_WIDTH  payloads; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- REQ_PAR_EN  in  NUM_REQ  per-requester parity enable.
- REQ_PAR_TYP  in  NUM_REQ  per-requester parity type.
- REQ_ACK  out  NUM_REQ  one-cycle, one-hot pulse; the payload was captured.
- TX_P_DATA  out  DATA_WIDTH  to P_DATA.
- TX_DATA_VALID  out  1  to DATA_VALID; one-cycle pulse.
- TX_PAR_EN  out  1  to PAR_EN.
- TX_PAR_TYP  out  1  to PAR_TYP.
- TX_BUSY  in  1  from Busy.
- GRANT_ID  out  max(1,$clog2(NUM_REQ))  index of the last granted requester.
- FRAME_DONE  out  1  one-cycle pulse when the frame's Busy falls.
- START_ERR  out  1  one-cycle pulse on start timeout.

## Operation
- All outputs are registered.
- Reset values:
  - All outputs 0.
  - Round-robin pointer 0, so requester 0 has top priority first.
  - State IDLE.
- States:
  - IDLE: when TX_BUSY=0 and any REQ_VALID=1:
    - select winner w, the first set bit at or after the pointer, wrapping modulo NUM_REQ;
    - capture REQ_DATA[w], REQ_PAR_EN[w] and REQ_PAR_TYP[w] into TX_P_DATA, TX_PAR_EN and TX_PAR_TYP;
    - set GRANT_ID=w and pointer=(w+1) mod NUM_REQ;
    - go to ISSUE.
  - IDLE with TX_BUSY=1: no grant; stay in IDLE.
  - ISSUE, one cycle: TX_DATA_VALID=1 and REQ_ACK[w]=1. Load the timeout counter with 0 and go to WAIT_START.
  - WAIT_START:
    - TX_BUSY=1 → WAIT_DONE.
    - Counter reaches START_TIMEOUT without Busy → START_ERR pulse, go to IDLE. The byte is dropped; it is not re-issued.
    - Otherwise increment the counter.
  - WAIT_DONE: TX_BUSY=0 → FRAME_DONE pulse, go to IDLE.
- TX_P_DATA, TX_PAR_EN and TX_PAR_TYP stay stable from ISSUE until the next grant. Parity configuration therefore never changes mid-frame.
- Requester contract:
  - REQ_DATA is sampled only on the grant edge.
  - The requester drops REQ_VALID in the cycle after it sees REQ_ACK.
  - A VALID still high during ISSUE/WAIT states is ignored.
- Simultaneous requests: exactly one grant per frame. Round-robin guarantees each active requester is served within NUM_REQ frames.
- REQ_VALID falling before ACK is legal. It is simply not granted.
- Reset mid-frame: everything returns to its reset values immediately. If the transmitter is still busy, IDLE waits for TX_BUSY=0 before the first grant.

## Timing
- Grant latency: REQ_VALID high in IDLE at edge n → TX_DATA_VALID and REQ_ACK high in cycle n+1 (one cycle).
- The transmitter's Busy is expected at most START_TIMEOUT cycles after the DATA_VALID cycle.
- Turnaround: TX_BUSY low observed at edge m → FRAME_DONE in cycle m+1 with state IDLE. The earliest next DATA_VALID is cycle m+2.
- Throughput: one frame per frame_duration + 3 cycles.
- The timeout counter saturates and never wraps.

## Structure
- Shared package uart_tx_sched_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT_START, WAIT_DONE);
  - the GRANT_ID width function;
  - the default START_TIMEOUT constant.
- Sub-module uart_rr_arbiter: combinational rotating-priority picker. It takes the request vector and pointer and returns a one-hot winner plus the index. The scheduler FSM instantiates it once.
- The top-level test wrapper instantiates uart_tx_scheduler with UART_TX_TOP.

## Test plan
- Single request: REQ_VALID[2]=1, REQ_DATA[2]=8'hA5, PAR_EN=1, PAR_TYP=0 → one-cycle TX_DATA_VALID with TX_P_DATA=8'hA5 and REQ_ACK=4'b0100. FRAME_DONE when Busy falls. The serial line shows A5 with even parity.
- Contention: all four VALID continuously, pointer 0 → grant order 0,1,2,3,0. GRANT_ID sequence matches, and no TX_DATA_VALID occurs while TX_BUSY=1.
- Per-requester config: requester 0 has parity off, requester 1 has odd parity → TX_PAR_EN/TX_PAR_TYP switch only between frames. They stay constant while Busy=1.
- Start timeout: TX_BUSY tied 0 after issue → START_ERR pulse exactly START_TIMEOUT+1 cycles after TX_DATA_VALID. Return to IDLE and grant the next requester.
- Reset mid-frame: assert RST low during WAIT_DONE with Busy high → all outputs 0 immediately. After release, no grant until TX_BUSY=0, then requester 0 is served first.
- Late VALID drop: VALID[1] raised then dropped while another frame is in flight → requester 1 is never acknowledged and no spurious frame occurs.
